// File: rtl/mips_muldiv_if.sv
// Command/result bundle between the execute stage and the multiply/divide unit.
interface mips_muldiv_if;
  logic        start;
  logic [5:0]  func;
  logic [31:0] S;
  logic [31:0] T;
  logic [31:0] q;
  logic        busy;
  logic        stall;

  modport master (output start, func, S, T, input q, busy, stall);
  modport slave  (input start, func, S, T, output q, busy, stall);
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS I multiply/divide unit with HI/LO: 32 radix-2 steps plus one sign-fix cycle.
// Commands arriving while an operation is in flight are stalled until the unit returns to idle.
module mips_muldiv (
  input  logic          clock,
  input  logic          reset,
  mips_muldiv_if.slave  bus
);
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic [31:0] hi, lo;
  logic [31:0] hi_w, lo_w, b_w;
  logic        is_div, neg_lo, neg_hi, dz;

  logic        known, accept, go, sgn, s_neg, t_neg;
  logic [31:0] mag_s, mag_t;
  logic [32:0] op_a, mul_s;
  logic [33:0] op_b, sum;
  logic [63:0] prod, prod_fix;

  always_comb begin
    known = 1'b0;
    case (bus.func)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: known = 1'b1;
      default: known = 1'b0;
    endcase
  end

  assign bus.busy  = (state != IDLE);
  assign bus.stall = bus.start & bus.busy & known;
  assign bus.q     = (bus.func == F_MFHI) ? hi : lo;
  assign accept    = bus.start & ~bus.busy & known;
  // Within the known set, bit 3 separates mult/div from the HI/LO moves.
  assign go        = accept & bus.func[3];

  // Even funct codes (MULT, DIV) are the signed variants.
  assign sgn   = ~bus.func[0];
  assign s_neg = sgn & bus.S[31];
  assign t_neg = sgn & bus.T[31];
  assign mag_s = s_neg ? -bus.S : bus.S;
  assign mag_t = t_neg ? -bus.T : bus.T;

  // Shared adder: add multiplicand for multiply, 33-bit trial subtract for divide.
  assign op_a  = is_div ? {hi_w, lo_w[31]} : {1'b0, hi_w};
  assign op_b  = is_div ? ~{2'b00, b_w} : {2'b00, b_w};
  assign sum   = {1'b0, op_a} + op_b + {33'd0, is_div};
  assign mul_s = lo_w[0] ? sum[32:0] : {1'b0, hi_w};

  assign prod     = {hi_w, lo_w};
  assign prod_fix = neg_lo ? -prod : prod;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt    <= 5'd0;
      hi     <= 32'd0;
      lo     <= 32'd0;
      hi_w   <= 32'd0;
      lo_w   <= 32'd0;
      b_w    <= 32'd0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      dz     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (go) begin
            is_div <= bus.func[1];
            cnt    <= 5'd0;
            hi_w   <= 32'd0;
            lo_w   <= bus.func[1] ? mag_s : mag_t;
            b_w    <= bus.func[1] ? mag_t : mag_s;
            neg_lo <= s_neg ^ t_neg;
            neg_hi <= s_neg;
            dz     <= bus.func[1] & (bus.T == 32'd0);
          end else if (accept && bus.func == F_MTHI) begin
            hi <= bus.S;
          end else if (accept && bus.func == F_MTLO) begin
            lo <= bus.S;
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (is_div) begin
            if (!sum[33]) begin
              hi_w <= sum[31:0];
              lo_w <= {lo_w[30:0], 1'b1};
            end else begin
              hi_w <= op_a[31:0];
              lo_w <= {lo_w[30:0], 1'b0};
            end
          end else begin
            hi_w <= mul_s[32:1];
            lo_w <= {mul_s[0], lo_w[31:1]};
          end
        end
        FIX: begin
          // Divide-by-zero remainder is |S|; re-applying S's sign restores S exactly.
          if (is_div) begin
            lo <= dz ? 32'hFFFF_FFFF : (neg_lo ? -lo_w : lo_w);
            hi <= neg_hi ? -hi_w : hi_w;
          end else begin
            {hi, lo} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit with its sequencer and the HI/LO register pair for the MIPS I core. It executes the SPECIAL-opcode functions MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO issued from the execute stage. It raises a stall toward the pipeline whenever the core issues a command while an operation is still in flight. Operations run in fixed latency, one radix-2 step per cycle, using a single shared 32-bit add/sub datapath.

## Interface
Parameters:
- none

Ports:
- clock  in  1  core clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  command valid from execute stage
- func  in  6  SPECIAL funct: 0x10 MFHI, 0x11 MTHI, 0x12 MFLO, 0x13 MTLO, 0x18 MULT, 0x19 MULTU, 0x1A DIV, 0x1B DIVU; other codes ignored
- S  in  32  rs operand (multiplicand / dividend / MTHI-MTLO data)
- T  in  32  rt operand (multiplier / divisor)
- q  out  32  MFHI/MFLO read data, combinational
- busy  out  1  operation in flight
- stall  out  1  command not accepted this cycle; core holds start/func/S/T stable

## Operation
- Reset values: HI = LO = 0, state IDLE, busy = 0, step counter = 0, q = LO (func don't-care), stall = 0.
- Acceptance: a command with a known func is accepted on a rising edge when start = 1 and busy = 0. stall = start & busy, combinational, for any known func. Unknown func never stalls and has no effect.
- States:
  - IDLE -> RUN on accepted MULT/MULTU/DIV/DIVU. Operands are latched; signed ops latch magnitudes plus result-sign flags.
  - RUN does 32 iterations; counter counts 0..31, then -> FIX.
  - FIX applies sign correction, writes HI/LO, then -> IDLE.
- MULT(U): shift-add over the magnitudes, giving a 64-bit product. FIX negates the product if exactly one operand was negative (MULT only), then writes {HI, LO}.
- DIV(U): restoring division over the magnitudes, using one 33-bit subtract per step.
  - FIX negates the quotient when operand signs differ (DIV only).
  - The remainder takes the dividend's sign.
  - Results: LO = quotient, HI = remainder.
- Divide by zero, signed or unsigned: LO = 0xFFFFFFFF, HI = S as issued, with no sign correction. Latency is the same as a normal divide.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0. This is a natural wrap with no exception.
- MTHI/MTLO: accepted only when idle; write S into HI/LO on the edge.
- MFHI/MFLO: q = HI for func 0x10, otherwise q = LO. The result is valid in any cycle where stall = 0.
- HI and LO are modified only in FIX or by MTHI/MTLO. During RUN, the architectural HI/LO keep their previous values; the working registers are separate.

## Timing
- Accepted mult/div at edge E0: busy = 1 after E0 through E32 (32 RUN cycles plus 1 FIX cycle = 33 cycles). HI/LO are updated at edge E33, and busy = 0 after E33.
- An MFHI issued in the cycle right after E0 stalls for 33 cycles and reads the new result in the first cycle where busy = 0.
- Back-to-back: a second MULT presented during busy stalls, then is accepted at E33. Its HI/LO land at E66.
- Asserting reset mid-RUN or mid-FIX aborts immediately and asynchronously: busy = 0 and HI = LO = 0. Deasserting reset takes effect on the next edge.
- Simultaneous start and FIX completion: start sees busy = 1 that cycle, so the command stalls and is accepted on the following edge.

## Test plan
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 busy cycles HI = 0xFFFFFFFE, LO = 0x00000001.
- MULT 0xFFFFFFFD (-3) x 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB. DIV -7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 0x00000005. DIV 0x80000000 / -1 -> LO = 0x80000000, HI = 0.
- MULT 3 x 4 then MFLO on the next cycle -> stall = 1 for exactly 33 cycles, then q = 0x0000000C with stall = 0.
- MTHI 0x1234 when idle, then MFHI -> q = 0x00001234. MTLO issued during busy -> stalls; LO is unchanged until acceptance.
- Start DIVU, assert reset at cycle 10 -> busy = 0, HI = LO = 0 immediately. After release, MFHI -> q = 0 with no stall.
